// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-thread destination-register scoreboard between issue and writeback.
// Latency: issue_ready is combinational from registered counters; updates land at the clk edge.
// Backpressure: issue_ready low stalls the presented instruction; wb and flush are never stalled.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   issue_valid/thread/instr, issue_ready   issue-stage handshake and hazard verdict
//   wb_valid/thread/dst                     writeback release of one pending destination
//   flush_valid/thread                      squash all pending writes of one thread
//   pending_any                             per-thread "has any outstanding write"
//   wb_err                                  sticky: a writeback found its counter already zero

package reg_scoreboard_pkg;
    typedef logic [1:0] threadid_t;
    typedef logic [4:0] regid_t;

    typedef enum logic [3:0] {
        OP_NOP      = 4'd0,
        OP_ADD      = 4'd1,
        OP_SUB      = 4'd2,
        OP_MUL      = 4'd3,
        OP_LDB      = 4'd4,
        OP_LDW      = 4'd5,
        OP_STB      = 4'd6,
        OP_STW      = 4'd7,
        OP_MOV      = 4'd8,
        OP_BEQ      = 4'd9,
        OP_JMP      = 4'd10,
        OP_TLBWRITE = 4'd11,
        OP_HALT     = 4'd12
    } opcode_t;

    typedef struct packed {
        regid_t dst;
        regid_t src1;
        regid_t src2;
    } rfmt_t;

    typedef struct packed {
        regid_t     dst;
        regid_t     src1;
        logic [4:0] imm;
    } ifmt_t;

    typedef union packed {
        rfmt_t r;
        ifmt_t i;
    } fields_t;

    typedef struct packed {
        opcode_t op;
        fields_t fields;
    } instr_t;
endpackage

module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NTHREADS = 4,
    parameter int NREGS    = 32,
    parameter int CNTW     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  threadid_t           issue_thread,
    input  instr_t              issue_instr,
    output logic                issue_ready,
    input  logic                wb_valid,
    input  threadid_t           wb_thread,
    input  regid_t              wb_dst,
    input  logic                flush_valid,
    input  threadid_t           flush_thread,
    output logic [NTHREADS-1:0] pending_any,
    output logic                wb_err
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [CNTW-1:0] r_cnt [NTHREADS][NREGS];
    logic            r_wb_err;

    logic            w_rd_src2;
    logic            w_wr_dst;
    regid_t          w_src1;
    regid_t          w_src2;
    regid_t          w_dst;
    logic [CNTW-1:0] w_cnt_src1;
    logic [CNTW-1:0] w_cnt_src2;
    logic [CNTW-1:0] w_cnt_dst;
    logic [CNTW-1:0] w_cnt_wb;
    logic            w_hazard;
    logic            w_issue_fire;
    logic            w_wb;
    logic            w_same_cnt;

    // Operand usage decode: which instructions read src2 and which write dst.
    always_comb begin
        w_rd_src2 = 1'b0;
        w_wr_dst  = 1'b0;
        case (issue_instr.op)
            OP_ADD, OP_SUB, OP_MUL: begin
                w_rd_src2 = 1'b1;
                w_wr_dst  = 1'b1;
            end
            OP_BEQ, OP_TLBWRITE: w_rd_src2 = 1'b1;
            OP_LDB, OP_LDW, OP_MOV: w_wr_dst = 1'b1;
            default: ;
        endcase
    end

    assign w_src1     = issue_instr.fields.r.src1;
    assign w_src2     = issue_instr.fields.r.src2;
    assign w_dst      = issue_instr.fields.r.dst;
    assign w_cnt_src1 = r_cnt[issue_thread][w_src1];
    assign w_cnt_src2 = r_cnt[issue_thread][w_src2];
    assign w_cnt_dst  = r_cnt[issue_thread][w_dst];
    assign w_cnt_wb   = r_cnt[wb_thread][wb_dst];

    // A saturated dst counter blocks issue so the counter can never wrap.
    assign w_hazard = (w_cnt_src1 != '0)
                    | (w_rd_src2 & (w_cnt_src2 != '0))
                    | (w_wr_dst & (w_cnt_dst == CNT_MAX));

    assign issue_ready = rst & ~w_hazard;

    // Flush of a thread suppresses that thread's issue and writeback this cycle.
    assign w_issue_fire = issue_valid & issue_ready & w_wr_dst
                        & ~(flush_valid & (flush_thread == issue_thread));
    assign w_wb         = wb_valid & ~(flush_valid & (flush_thread == wb_thread));

    // Increment and decrement of the same counter cancel, including the zero case.
    assign w_same_cnt = w_issue_fire & w_wb & (issue_thread == wb_thread) & (w_dst == wb_dst);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < NTHREADS; t++) begin
                for (int r = 0; r < NREGS; r++) begin
                    r_cnt[t][r] <= '0;
                end
            end
            r_wb_err <= 1'b0;
        end else begin
            for (int t = 0; t < NTHREADS; t++) begin
                for (int r = 0; r < NREGS; r++) begin
                    if (flush_valid && (flush_thread == threadid_t'(t))) begin
                        r_cnt[t][r] <= '0;
                    end else if (w_issue_fire && !w_same_cnt &&
                                 (issue_thread == threadid_t'(t)) && (w_dst == regid_t'(r))) begin
                        r_cnt[t][r] <= r_cnt[t][r] + CNTW'(1);
                    end else if (w_wb && !w_same_cnt &&
                                 (wb_thread == threadid_t'(t)) && (wb_dst == regid_t'(r)) &&
                                 (r_cnt[t][r] != '0)) begin
                        r_cnt[t][r] <= r_cnt[t][r] - CNTW'(1);
                    end
                end
            end
            if (w_wb && !w_same_cnt && (w_cnt_wb == '0)) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    always_comb begin
        pending_any = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            for (int r = 0; r < NREGS; r++) begin
                if (r_cnt[t][r] != '0) begin
                    pending_any[t] = 1'b1;
                end
            end
        end
    end

    assign wb_err = r_wb_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: table-driven check of reg_scoreboard with an expectation queue.
// Latency: each vector occupies one clk cycle; ready is sampled before the edge, state after it.
// Backpressure: none; the bench drives every vector regardless of issue_ready.

module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic            clk;
    logic            rst;
    logic            issue_valid;
    threadid_t       issue_thread;
    instr_t          issue_instr;
    logic            issue_ready;
    logic            wb_valid;
    threadid_t       wb_thread;
    regid_t          wb_dst;
    logic            flush_valid;
    threadid_t       flush_thread;
    logic [3:0]      pending_any;
    logic            wb_err;

    reg_scoreboard #(.NTHREADS(4), .NREGS(32), .CNTW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_thread (issue_thread),
        .issue_instr  (issue_instr),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_thread    (wb_thread),
        .wb_dst       (wb_dst),
        .flush_valid  (flush_valid),
        .flush_thread (flush_thread),
        .pending_any  (pending_any),
        .wb_err       (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        threadid_t  it;
        opcode_t    op;
        regid_t     d;
        regid_t     s1;
        regid_t     s2;
        logic       wv;
        threadid_t  wt;
        regid_t     wd;
        logic       fv;
        threadid_t  ft;
        logic       e_rdy;
        logic [3:0] e_pend;
        logic       e_err;
    } vec_t;

    typedef struct {
        int         idx;
        logic       rdy;
        logic [3:0] pend;
        logic       err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total;
    int   bad;

    function automatic instr_t mk_instr(opcode_t op, regid_t d, regid_t s1, regid_t s2);
        instr_t i;
        i                = '0;
        i.op             = op;
        i.fields.r.dst   = d;
        i.fields.r.src1  = s1;
        i.fields.r.src2  = s2;
        return i;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    task automatic addv(input int iv, input int it, input opcode_t op, input int d, input int s1,
                        input int s2, input int wv, input int wt, input int wd, input int fv,
                        input int ft, input int rdy, input int pend, input int err);
        vec_t v;
        v.iv     = iv[0];
        v.it     = threadid_t'(it);
        v.op     = op;
        v.d      = regid_t'(d);
        v.s1     = regid_t'(s1);
        v.s2     = regid_t'(s2);
        v.wv     = wv[0];
        v.wt     = threadid_t'(wt);
        v.wd     = regid_t'(wd);
        v.fv     = fv[0];
        v.ft     = threadid_t'(ft);
        v.e_rdy  = rdy[0];
        v.e_pend = 4'(pend);
        v.e_err  = err[0];
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        issue_valid  = v.iv;
        issue_thread = v.it;
        issue_instr  = mk_instr(v.op, v.d, v.s1, v.s2);
        wb_valid     = v.wv;
        wb_thread    = v.wt;
        wb_dst       = v.wd;
        flush_valid  = v.fv;
        flush_thread = v.ft;
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        issue_thread = '0;
        issue_instr  = '0;
        wb_valid     = 1'b0;
        wb_thread    = '0;
        wb_dst       = '0;
        flush_valid  = 1'b0;
        flush_thread = '0;
    endtask

    initial begin
        logic r_s;
        exp_t e;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        idle_inputs();

        //   iv it op          d  s1 s2  wv wt wd  fv ft  rdy pend     err
        addv(1, 0, OP_ADD,      3, 1, 2,  0, 0, 0,  0, 0,  1, 'b0001, 0); // 0
        addv(1, 1, OP_SUB,      4, 3, 5,  0, 0, 0,  0, 0,  1, 'b0011, 0); // 1 other thread unaffected
        addv(1, 0, OP_SUB,      4, 3, 5,  1, 0, 3,  0, 0,  0, 'b0010, 0); // 2 RAW stall, no bypass
        addv(1, 0, OP_SUB,      4, 3, 5,  0, 0, 0,  0, 0,  1, 'b0011, 0); // 3 ready after wb
        addv(0, 0, OP_NOP,      0, 0, 0,  1, 0, 4,  0, 0,  1, 'b0010, 0); // 4
        addv(0, 0, OP_NOP,      0, 0, 0,  1, 1, 4,  0, 0,  1, 'b0000, 0); // 5
        addv(1, 2, OP_LDW,      7, 1, 7,  0, 0, 0,  0, 0,  1, 'b0100, 0); // 6 ldw ignores src2
        addv(1, 2, OP_LDW,      7, 1, 7,  0, 0, 0,  0, 0,  1, 'b0100, 0); // 7
        addv(1, 2, OP_LDW,      7, 1, 7,  0, 0, 0,  0, 0,  1, 'b0100, 0); // 8 count = 3
        addv(1, 2, OP_LDW,      7, 1, 7,  0, 0, 0,  0, 0,  0, 'b0100, 0); // 9 saturated
        addv(1, 2, OP_STW,      7, 1, 2,  0, 0, 0,  0, 0,  1, 'b0100, 0); // 10 non-writer not blocked
        addv(1, 2, OP_BEQ,      0, 1, 7,  0, 0, 0,  0, 0,  0, 'b0100, 0); // 11 beq reads src2
        addv(1, 2, OP_LDW,      7, 1, 7,  1, 2, 7,  0, 0,  0, 'b0100, 0); // 12 wb frees one slot
        addv(1, 2, OP_LDW,      7, 1, 7,  0, 0, 0,  0, 0,  1, 'b0100, 0); // 13 accepted next cycle
        addv(0, 0, OP_NOP,      0, 0, 0,  1, 2, 7,  0, 0,  1, 'b0100, 0); // 14
        addv(0, 0, OP_NOP,      0, 0, 0,  1, 2, 7,  0, 0,  1, 'b0100, 0); // 15
        addv(0, 0, OP_NOP,      0, 0, 0,  1, 2, 7,  0, 0,  1, 'b0000, 0); // 16
        addv(1, 1, OP_ADD,      6, 1, 2,  0, 0, 0,  0, 0,  1, 'b0010, 0); // 17
        addv(1, 1, OP_ADD,      6, 1, 2,  1, 1, 6,  0, 0,  1, 'b0010, 0); // 18 same counter cancels
        addv(1, 1, OP_MOV,      8, 1, 0,  1, 1, 8,  0, 0,  1, 'b0010, 0); // 19 cancel at zero, no err
        addv(0, 0, OP_NOP,      0, 0, 0,  1, 1, 6,  0, 0,  1, 'b0000, 0); // 20 counter was still 1
        addv(1, 0, OP_ADD,     11, 1, 2,  0, 0, 0,  0, 0,  1, 'b0001, 0); // 21
        addv(1, 0, OP_ADD,     12, 1, 2,  1, 0, 11, 0, 0,  1, 'b0001, 0); // 22 different counters
        addv(0, 0, OP_NOP,      0, 0, 0,  1, 0, 12, 0, 0,  1, 'b0000, 0); // 23
        addv(1, 0, OP_ADD,      3, 1, 2,  0, 0, 0,  0, 0,  1, 'b0001, 0); // 24
        addv(1, 3, OP_ADD,      5, 1, 2,  0, 0, 0,  0, 0,  1, 'b1001, 0); // 25
        addv(1, 3, OP_MOV,      6, 1, 0,  0, 0, 0,  0, 0,  1, 'b1001, 0); // 26
        addv(1, 3, OP_ADD,     13, 1, 2,  1, 3, 9,  1, 3,  1, 'b0001, 0); // 27 flush beats issue+wb
        addv(1, 3, OP_ADD,     14, 5, 13, 0, 0, 0,  0, 0,  1, 'b1001, 0); // 28 r5, r13 clear
        addv(1, 0, OP_ADD,     15, 1, 2,  0, 0, 0,  1, 3,  1, 'b0001, 0); // 29 other thread issues
        addv(1, 0, OP_SUB,      4, 3, 5,  0, 0, 0,  0, 0,  0, 'b0001, 0); // 30 thread 0 kept r3
        addv(0, 0, OP_NOP,      0, 0, 0,  1, 1, 9,  0, 0,  1, 'b0001, 1); // 31 wb on zero counter
        addv(0, 0, OP_NOP,      0, 0, 0,  0, 0, 0,  0, 0,  1, 'b0001, 1); // 32 error is sticky

        // Reset held: ready forced low even for a hazard-free instruction.
        @(negedge clk);
        issue_valid = 1'b1;
        issue_instr = mk_instr(OP_ADD, 5'd3, 5'd1, 5'd2);
        #1;
        chk("rst_ready", -1, 32'(issue_ready), 32'd0);
        chk("rst_pend",  -1, 32'(pending_any), 32'd0);
        chk("rst_err",   -1, 32'(wb_err),      32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            sb.push_back('{idx: i, rdy: vecs[i].e_rdy, pend: vecs[i].e_pend, err: vecs[i].e_err});
            #3 r_s = issue_ready;
            @(negedge clk);
            if (sb.size() == 0) begin
                chk("sb_empty", i, 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("issue_ready", e.idx, 32'(r_s),         32'(e.rdy));
                chk("pending_any", e.idx, 32'(pending_any), 32'(e.pend));
                chk("wb_err",      e.idx, 32'(wb_err),      32'(e.err));
            end
        end

        // Mid-stream reset: everything clears without waiting for an edge.
        drive(vecs[30]);
        #2;
        chk("pre_rst_ready", 100, 32'(issue_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready", 100, 32'(issue_ready), 32'd0);
        chk("midrst_pend",  100, 32'(pending_any), 32'd0);
        chk("midrst_err",   100, 32'(wb_err),      32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", 101, 32'(issue_ready), 32'd1);
        chk("post_rst_pend",  101, 32'(pending_any), 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("post_rst_issue", 102, 32'(pending_any), 32'b0001);
        chk("post_rst_err",   102, 32'(wb_err),      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Per-thread register scoreboard that tracks in-flight destination writes from issue to writeback and tells the issue stage whether the current instruction may proceed. It complements the history-window hazard check. Destinations are marked pending when an instruction issues and released when the writeback stage retires it. This lets hazards be resolved on actual completion rather than a fixed 8-deep window, and lets a thread's pending state be flushed on a squash. It sits between decode/issue and writeback, using the common `instr_t`, `threadid_t` and `opcode` definitions.

## Interface

- NTHREADS, 4, number of hardware threads; `threadid_t` must cover it
- NREGS, 32, architectural registers per thread; indexed by `instr_t` `fields.r` register fields
- CNTW, 2, width of each per-(thread, register) pending counter; maximum count is 2^CNTW-1

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  an instruction is presented for issue
- issue_thread  in  threadid_t  thread of the presented instruction
- issue_instr  in  instr_t  presented instruction; uses `op`, `fields.r.src1`, `fields.r.src2`, `fields.r.dst`
- issue_ready  out  1  presented instruction has no outstanding RAW or counter-overflow hazard
- wb_valid  in  1  writeback retires one register write
- wb_thread  in  threadid_t  thread of the retiring write
- wb_dst  in  reg index  destination register being released
- flush_valid  in  1  squash all pending writes of one thread
- flush_thread  in  threadid_t  thread to flush
- pending_any  out  NTHREADS  bit t is set when thread t has any nonzero counter
- wb_err  out  1  sticky; set when a writeback hits a zero counter

## Operation

- State: one CNTW-bit counter cnt[t][r] per thread and register, plus a sticky wb_err.
- src2 use: the instruction reads src2 when `op` is one of add, sub, mul, beq or tlbwrite.
- Destination write: the instruction writes dst when `op` is one of add, sub, mul, ldb, ldw or mov.
- issue_ready is 0 if any of these holds, and 1 otherwise:
  - cnt[thread][src1] != 0;
  - the instruction reads src2 and cnt[thread][src2] != 0;
  - the instruction writes dst and cnt[thread][dst] is at its maximum.
- issue_ready is computed combinationally from the registered counters only. There is no same-cycle writeback bypass.
- issue fire = issue_valid && issue_ready && the instruction writes dst && !(flush_valid && flush_thread == issue_thread).
  - On issue fire, cnt[issue_thread][dst] increments.
- wb = wb_valid && !(flush_valid && flush_thread == wb_thread).
  - On wb, cnt[wb_thread][wb_dst] decrements.
  - If that counter is already 0, it stays 0 and wb_err is set.
- Issue fire and wb on the same counter in the same cycle: the counter is unchanged, and wb_err is not set even if the counter was 0.
- Issue fire and wb on different counters in the same cycle: both updates apply.
- flush: every cnt[flush_thread][*] becomes 0.
  - Flush has priority over same-thread issue and writeback that cycle.
  - Other threads update normally.
- pending_any[t] is the OR of the nonzero flags of all cnt[t][*], taken from the registered state.

## Timing

- Reset (rst low, asynchronous): all counters 0, wb_err 0, pending_any all 0. issue_ready is forced to 0 while rst is low.
- After rst deasserts, issue_ready reflects the zero counters, so it is 1 in the first cycle.
- Counter updates take effect at the clk edge. issue_ready and pending_any reflect them from the next cycle.
- Issue-to-dependent-ready latency: a dependent instruction stalls until the cycle after the matching wb.
- Flush latency: counters clear at the edge; the flushed thread's dependents become ready the next cycle.
- Reset mid-operation discards all pending state immediately. There is no drain.
- wb_err stays set until reset.

## Test plan

- Reset, then present add r3,r1,r2 on thread 0 -> issue_ready=1; after the edge, cnt[0][3]=1 and pending_any=0001.
- Next cycle, present sub r4,r3,r5 on thread 0 -> issue_ready=0. Assert wb thread 0 dst 3 -> issue_ready=1 one cycle later and pending_any=0000.
- Present sub r4,r3,r5 on thread 1 while cnt[0][3]=1 -> issue_ready=1 (per-thread isolation).
- Issue three ldw to r7 on thread 2 -> counter reaches 3. A fourth ldw r7 -> issue_ready=0. One wb to r7 -> the fourth is accepted next cycle.
- Issue to r6 and wb to r6, same thread, same cycle, starting from cnt=1 -> cnt stays 1 and wb_err stays 0. A wb to r9 with cnt 0 -> wb_err=1 and stays set.
- With threads 0 and 3 pending, flush thread 3 together with a same-cycle issue on thread 3 -> all of thread 3's counters are 0, the issue is not recorded, thread 0 is untouched, and pending_any=0001. Drop rst mid-stream -> all outputs go to their reset values immediately.
